// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory port arbiter.
//   owner_e          : issue-owner / FSM state encoding (IDLE=00, IF_ACC=01, D_ACC=10)
//   FETCH_FUNCT3     : access size used for every instruction fetch (LW)
//   STARVE_MAX_DEFAULT : default number of fetch denials before fetch is forced through
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_ACC = 2'b01,
    D_ACC  = 2'b10
  } owner_e;

  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
// Counts consecutive cycles in which a request is pending but not granted,
// saturating at STARVE_MAX. Any grant, or a dropped request, clears it.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   req    : request pending this cycle
//   gnt    : request granted this cycle
//   at_max : counter has reached STARVE_MAX
module arb_starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic at_max
);

  localparam logic [2:0] CntMax = 3'(STARVE_MAX);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next count: clear on grant or idle, otherwise step up until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = 3'd0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates a single memory port between an instruction-fetch requester and a
// data requester. Grants are combinational, one per cycle, data wins by default.
// Reads return one cycle after grant; writes complete in the grant cycle.
// Configuration macro: ARB_STARVE_GUARD_EN -- when defined, a fetch that has been
// denied STARVE_MAX consecutive cycles wins over data once.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   if_req/if_addr                  : fetch request and address
//   if_gnt/if_rvalid/if_rdata       : fetch grant, read valid, read data
//   d_req/d_we/d_funct3/d_addr/d_wdata : data request and command
//   d_gnt/d_rvalid/d_rdata          : data grant, read valid, read data
//   mem_re/mem_we/mem_funct3/mem_addr/mem_wdata : memory command
//   mem_rdata                       : memory read data, one cycle after mem_re
//   owner                           : owner of the previous cycle's read issue
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  owner_e state_q;
  owner_e state_d;
  logic   ifGnt;
  logic   dGnt;

`ifdef ARB_STARVE_GUARD_EN
  logic starveAtMax;

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .req   (if_req),
    .gnt   (ifGnt),
    .at_max(starveAtMax)
  );

  // Grants are held off during reset so every output is quiet regardless of inputs.
  always_comb begin
    ifGnt = 1'b0;
    dGnt  = 1'b0;
    if (rst) begin
      if (if_req && (!d_req || starveAtMax)) begin
        ifGnt = 1'b1;
      end else if (d_req) begin
        dGnt = 1'b1;
      end
    end
  end
`else
  // Strict data priority; grants are held off during reset.
  always_comb begin
    ifGnt = 1'b0;
    dGnt  = 1'b0;
    if (rst) begin
      if (d_req) begin
        dGnt = 1'b1;
      end else if (if_req) begin
        ifGnt = 1'b1;
      end
    end
  end
`endif

  // Memory command mux: the winner's command, or all zeros with no grant.
  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (dGnt) begin
      mem_re     = !d_we;
      mem_we     = d_we;
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end else if (ifGnt) begin
      mem_re     = 1'b1;
      mem_funct3 = FETCH_FUNCT3;
      mem_addr   = if_addr;
    end
  end

  // Writes finish in the grant cycle, so only reads move the FSM out of IDLE.
  always_comb begin
    state_d = IDLE;
    if (ifGnt) begin
      state_d = IF_ACC;
    end else if (dGnt && !d_we) begin
      state_d = D_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign if_gnt    = ifGnt;
  assign d_gnt     = dGnt;
  assign if_rvalid = (state_q == IF_ACC);
  assign d_rvalid  = (state_q == D_ACC);
  assign if_rdata  = (state_q == IF_ACC) ? mem_rdata : '0;
  assign d_rdata   = (state_q == D_ACC) ? mem_rdata : '0;
  assign owner     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small word memory model behind the port.
// Memory word at byte address A is preloaded with 32'hC0DE_0000 | A.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  owner;

  logic [31:0] memArray [0:63];
  int          compareCount;
  int          mismatchCount;
  logic [9:0]  expIfPattern;

  mem_port_arbiter #(
    .ADDR_W(8),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_funct3(mem_funct3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: synchronous word read, write on mem_we.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= memArray[mem_addr[7:2]];
    end
    if (mem_we) begin
      memArray[mem_addr[7:2]] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a new input vector just after the rising edge.
  task automatic applyStimulus(input logic ifReq, input logic [7:0] ifAddr,
                               input logic dReq, input logic dWe,
                               input logic [7:0] dAddr, input logic [31:0] dWdata);
    @(posedge clk);
    #1;
    if_req   = ifReq;
    if_addr  = ifAddr;
    d_req    = dReq;
    d_we     = dWe;
    d_funct3 = 3'b010;
    d_addr   = dAddr;
    d_wdata  = dWdata;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    mem_rdata     = 32'h5A5A_5A5A;
    for (int i = 0; i < 64; i++) begin
      memArray[i] = 32'hC0DE_0000 | (i * 4);
    end

    // Reset held with both requesters active: everything must stay quiet.
    rst      = 1'b0;
    if_req   = 1'b1;
    if_addr  = 8'h04;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_funct3 = 3'b010;
    d_addr   = 8'h10;
    d_wdata  = 32'h1234_5678;
    #3;
    checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    rst    = 1'b1;

    // Fetch stream 0x00, 0x04, 0x08 back to back.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("f0_if_gnt", 32'(if_gnt), 32'd1);
    checkOutput("f0_mem_re", 32'(mem_re), 32'd1);
    checkOutput("f0_funct3", 32'(mem_funct3), 32'd2);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("f1_if_gnt", 32'(if_gnt), 32'd1);
    checkOutput("f1_mem_addr", 32'(mem_addr), 32'h04);
    checkOutput("f1_if_rvalid", 32'(if_rvalid), 32'd1);
    checkOutput("f1_if_rdata", if_rdata, 32'hC0DE_0000);
    checkOutput("f1_owner", 32'(owner), 32'd1);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("f2_if_gnt", 32'(if_gnt), 32'd1);
    checkOutput("f2_if_rdata", if_rdata, 32'hC0DE_0004);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("f3_if_gnt", 32'(if_gnt), 32'd0);
    checkOutput("f3_if_rvalid", 32'(if_rvalid), 32'd1);
    checkOutput("f3_if_rdata", if_rdata, 32'hC0DE_0008);
    checkOutput("f3_mem_re", 32'(mem_re), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("f4_if_rvalid", 32'(if_rvalid), 32'd0);
    checkOutput("f4_if_rdata", if_rdata, 32'd0);
    checkOutput("f4_owner", 32'(owner), 32'd0);

    // Simultaneous fetch 0x0C and data read 0x40: data first, fetch next cycle.
    applyStimulus(1'b1, 8'h0C, 1'b1, 1'b0, 8'h40, 32'h0);
    @(negedge clk);
    checkOutput("c0_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("c0_if_gnt", 32'(if_gnt), 32'd0);
    checkOutput("c0_mem_addr", 32'(mem_addr), 32'h40);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("c1_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("c1_d_rdata", d_rdata, 32'hC0DE_0040);
    checkOutput("c1_owner", 32'(owner), 32'd2);
    checkOutput("c1_if_gnt", 32'(if_gnt), 32'd1);
    checkOutput("c1_mem_addr", 32'(mem_addr), 32'h0C);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("c2_if_rdata", if_rdata, 32'hC0DE_000C);
    checkOutput("c2_d_rvalid", 32'(d_rvalid), 32'd0);

    // Data write 0x20 then read it back.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("w0_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("w0_mem_we", 32'(mem_we), 32'd1);
    checkOutput("w0_mem_re", 32'(mem_re), 32'd0);
    checkOutput("w0_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    checkOutput("w1_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("w1_owner", 32'(owner), 32'd0);
    checkOutput("w1_mem_we", 32'(mem_we), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("w2_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("w2_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Both requesting continuously for 10 cycles.
`ifdef ARB_STARVE_GUARD_EN
    expIfPattern = 10'b10_0001_0000;
`else
    expIfPattern = 10'b00_0000_0000;
`endif
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h44, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("s%0d_if_gnt", i), 32'(if_gnt), 32'(expIfPattern[i]));
      checkOutput($sformatf("s%0d_d_gnt", i), 32'(d_gnt), 32'(!expIfPattern[i]));
    end

    // Reset in the cycle after a data-read grant discards the response.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 32'h0);
    @(negedge clk);
    checkOutput("r0_d_gnt", 32'(d_gnt), 32'd1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    rst   = 1'b0;
    #1;
    checkOutput("r1_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("r1_d_rdata", d_rdata, 32'd0);
    checkOutput("r1_owner", 32'(owner), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 8'h08;
    #1;
    checkOutput("r2_if_gnt", 32'(if_gnt), 32'd1);
    checkOutput("r2_d_rvalid", 32'(d_rvalid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("r3_if_rdata", if_rdata, 32'hC0DE_0008);
    checkOutput("r3_d_rvalid", 32'(d_rvalid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("r4_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("r4_if_rvalid", 32'(if_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
